// File: rtl/pipe_pkg.sv
// ============================================================================
// Package : pipe_pkg
// Purpose : Shared types for the 5-stage pipeline hazard control slice:
//           hazard FSM state encoding, the hardwired-zero register index and
//           the hazard-cause priority encoding used by hazard_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // Hazard sequencer states
  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  // $zero is hardwired, so a load to it never creates a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Hazard causes seen in RUN, numerically ordered by priority
  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_JUMP     = 2'd1,
    CAUSE_LOAD_USE = 2'd2,
    CAUSE_BRANCH   = 2'd3
  } cause_t;

  // Branch beats load-use beats jump
  function automatic cause_t hazard_cause(input logic br_taken,
                                          input logic load_use,
                                          input logic jump);
    cause_t c;
    c = CAUSE_NONE;
    if (br_taken)      c = CAUSE_BRANCH;
    else if (load_use) c = CAUSE_LOAD_USE;
    else if (jump)     c = CAUSE_JUMP;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
// ============================================================================
// Module  : hazard_perf_cnt
// Purpose : Pair of saturating event counters for pipeline stall and flush
//           cycles. Each counter increments once per cycle its event input is
//           high and sticks at all-ones.
// Ports   : clk        in   clock, rising edge
//           reset      in   asynchronous active-low reset (clears counters)
//           stall      in   stall event this cycle
//           flush      in   flush event this cycle
//           stall_cnt  out  CNT_W-bit stall-cycle count
//           flush_cnt  out  CNT_W-bit flush-cycle count
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module  : hazard_ctrl
// Purpose : Hazard controller for a 5-stage MIPS pipeline. Detects load-use,
//           taken-branch/jump and multi-cycle MDU hazards and drives the PC,
//           IF/ID and ID/EX enables plus the flush/bubble lines. A two-state
//           FSM (RUN / MDU_WAIT) holds the pipeline while an MDU op is busy,
//           abandoning the wait after MDU_TIMEOUT cycles with a sticky error.
// Config  : HAZARD_PERF_EN - when defined, adds stall_cnt/flush_cnt outputs
//           backed by saturating counters (hazard_perf_cnt).
// Ports   : clk, reset (async active-low), rs_id, rt_id, use_rs_id,
//           use_rt_id, memrd_ex, rt_ex, br_taken_ex, jump_id, mdu_start_ex,
//           mdu_done -> pc_we, ifid_we, ifid_flush, idex_we, idex_null,
//           exmem_null, err_timeout [, stall_cnt, flush_cnt]
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             memrd_ex,
  input  logic [4:0]       rt_ex,
  input  logic             br_taken_ex,
  input  logic             jump_id,
  input  logic             mdu_start_ex,
  input  logic             mdu_done,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_null,
  output logic             exmem_null,
  output logic             err_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int              TIMER_W    = $clog2(MDU_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MDU_TIMEOUT - 1);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               load_use;
  cause_t             cause;

  assign load_use = memrd_ex && (rt_ex != REG_ZERO) &&
                    ((use_rs_id && (rs_id == rt_ex)) ||
                     (use_rt_id && (rt_id == rt_ex)));

  assign cause = hazard_cause(br_taken_ex, load_use, jump_id);

  // Sequencer: only state, timer and the sticky error are registered.
  // A taken branch in EX means the MDU op is being killed, so no wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      timer       <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mdu_start_ex && !mdu_done && !br_taken_ex) begin
            state <= MDU_WAIT;
            timer <= '0;
          end
        end
        MDU_WAIT: begin
          if (mdu_done) begin
            state <= RUN;
            timer <= '0;
          end else if (timer == TIMER_LAST) begin
            state       <= RUN;
            timer       <= '0;
            err_timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= RUN;
          timer <= '0;
        end
      endcase
    end
  end

  // Control lines are combinational from state and inputs. Reset is folded
  // in so the pipeline registers see bubbles while reset is held.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_we    = 1'b1;
    idex_null  = 1'b0;
    exmem_null = 1'b0;
    if (!reset) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_null  = 1'b1;
      exmem_null = 1'b1;
    end else if (state == MDU_WAIT) begin
      // Freeze everything up to EX; EX/MEM gets bubbles until the result lands
      if (!mdu_done) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_we    = 1'b0;
        exmem_null = 1'b1;
      end
    end else begin
      case (cause)
        CAUSE_BRANCH: begin
          ifid_flush = 1'b1;
          idex_null  = 1'b1;
        end
        CAUSE_LOAD_USE: begin
          // Hold PC and IF/ID; ID/EX takes a bubble, which clears memrd_ex
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          idex_null = 1'b1;
        end
        CAUSE_JUMP: begin
          ifid_flush = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (clk),
    .reset     (reset),
    .stall     (!pc_we),
    .flush     (ifid_flush),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

`default_nettype wire
